// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer feeding the accumulator ALU.
// Define CU_SINGLE_STEP_EN to add the step input and the STEP_WAIT state.
module control_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] mem_rdata,
  input  logic        z_flag,
  output logic [11:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ac_to_bus,
  output logic [3:0]  alu_control,
  output logic [15:0] instruction,
  output logic        halted
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPREAD, S_EXEC, S_STORE, S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

`ifdef CU_SINGLE_STEP_EN
  localparam state_t RST_STATE  = S_STEP_WAIT;
  localparam state_t DONE_STATE = S_STEP_WAIT;
`else
  localparam state_t RST_STATE  = S_FETCH;
  localparam state_t DONE_STATE = S_FETCH;
`endif

  state_t          state;
  logic [11:0]     pc;
  logic [15:0]     ir;
  logic [CW-1:0]   cnt;

  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        mem_op;

  assign opcode  = ir[15:12];
  assign operand = ir[11:0];
  assign mem_op  = opcode inside {[4'h1:4'h5]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RST_STATE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (cnt == LAST) begin
            ir    <= mem_rdata;
            pc    <= pc + 12'd1;
            cnt   <= '0;
            state <= S_DECODE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (mem_op)              state <= S_OPREAD;
          else if (opcode == 4'hA) state <= S_STORE;
          else if (opcode == 4'hF) state <= S_HALT;
          else                     state <= S_EXEC;
        end
        S_OPREAD: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_EXEC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EXEC: begin
          // z_flag still reflects AC from the previous instruction here
          if (opcode == 4'hB || (opcode == 4'hC && z_flag)) pc <= operand;
          state <= DONE_STATE;
        end
        S_STORE: state <= DONE_STATE;
        S_HALT:  state <= S_HALT;
`ifdef CU_SINGLE_STEP_EN
        S_STEP_WAIT: if (step) state <= S_FETCH;
`endif
        default: state <= RST_STATE;
      endcase
    end
  end

  // Strobes are gated by reset_n so an abort drops them in the same cycle
  always_comb begin
    mem_addr    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ac_to_bus   = 1'b0;
    alu_control = 4'h0;
    halted      = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          mem_addr = pc;
          mem_read = 1'b1;
        end
        S_OPREAD: begin
          mem_addr = operand;
          mem_read = 1'b1;
        end
        S_EXEC: begin
          alu_control = (opcode <= 4'h9) ? opcode : 4'h0;
          if (mem_op) begin
            mem_addr = operand;
            mem_read = 1'b1;
          end
        end
        S_STORE: begin
          mem_addr  = operand;
          mem_write = 1'b1;
          ac_to_bus = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign instruction = ir;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: memory + accumulator ALU environment, vector table,
// corner-case sequences and random programs checked against an ISA-level model.
module tb_control_unit;
  localparam int L = 3;
`ifdef CU_SINGLE_STEP_EN
  localparam int SW = 1;
  logic step;
`else
  localparam int SW = 0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mem_rdata;
  logic        z_flag;
  logic [11:0] mem_addr;
  logic        mem_read, mem_write, ac_to_bus, halted;
  logic [3:0]  alu_control;
  logic [15:0] instruction;

  logic [15:0] mem [4096];
  logic [15:0] rm  [4096];
  logic [15:0] ac = '0;

  assign mem_rdata = mem[mem_addr];
  assign z_flag    = (ac == 16'h0);

  always #5 clock = ~clock;

  control_unit #(.MEM_LATENCY(L)) dut (
    .clock(clock), .reset_n(reset_n),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_rdata(mem_rdata), .z_flag(z_flag), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .ac_to_bus(ac_to_bus),
    .alu_control(alu_control), .instruction(instruction), .halted(halted)
  );

  int checks = 0, passed = 0, both_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] ins);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (c)
      4'h1: return a + b;
      4'h2: return a - b;
      4'h3: return p[15:0];
      4'h4: return (b == 0) ? a : a / b;
      4'h5: return b;
      4'h6: return {4'h0, ins[11:0]};
      4'h7: return a + 16'd1;
      4'h8: return a - 16'd1;
      4'h9: return 16'h0;
      default: return a;
    endcase
  endfunction

  // One clock: ALU and memory react to what the DUT drove before the edge
  task automatic tick();
    logic [3:0]  s_alu;
    logic [15:0] s_rd, s_ins, s_ac;
    logic [11:0] s_addr;
    logic        s_wr, s_atb;
    s_alu = alu_control; s_rd = mem_rdata; s_ins = instruction; s_ac = ac;
    s_addr = mem_addr; s_wr = mem_write; s_atb = ac_to_bus;
    if (mem_read && mem_write) both_cnt++;
    @(posedge clock);
    #1;
    if (s_wr && s_atb) mem[s_addr] = s_ac;
    if (s_alu != 4'h0) ac = alu_fn(s_alu, s_ac, s_rd, s_ins);
    @(negedge clock);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    ac = '0;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b1;
`endif
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    repeat (SW) tick();
  endtask

  task automatic run_to_halt(output int n, output logic [11:0] lf, output int acnt,
                             output logic [3:0] alast, output int wcnt, output logic [11:0] waddr);
    n = 1; lf = '0; acnt = 0; alast = '0; wcnt = 0; waddr = '0;
    while (!halted && n < 400) begin
      if (mem_read) lf = mem_addr;
      if (alu_control != 4'h0) begin acnt++; alast = alu_control; end
      if (mem_write) begin wcnt++; waddr = mem_addr; end
      tick();
      n++;
    end
  endtask

  // ISA-level reference: cycle cost, final AC, memory effects
  task automatic model_run(output int cyc, output logic [15:0] mac);
    logic [11:0] pc, a;
    logic [15:0] ins, b;
    logic [3:0]  op;
    logic [31:0] p;
    cyc = 0; mac = '0; pc = '0;
    for (int g = 0; g < 100; g++) begin
      ins = rm[pc]; pc = pc + 12'd1; op = ins[15:12]; a = ins[11:0];
      if (op == 4'hF) begin cyc += L + 1; break; end
      b = rm[a];
      p = 32'(mac) * 32'(b);
      if (op >= 4'h1 && op <= 4'h5) cyc += 2 * L + 2 + SW;
      else                          cyc += L + 2 + SW;
      case (op)
        4'h1: mac = mac + b;
        4'h2: mac = mac - b;
        4'h3: mac = p[15:0];
        4'h4: if (b != 0) mac = mac / b;
        4'h5: mac = b;
        4'h6: mac = {4'h0, a};
        4'h7: mac = mac + 1;
        4'h8: mac = mac - 1;
        4'h9: mac = 0;
        4'hA: rm[a] = mac;
        4'hB: pc = a;
        4'hC: if (mac == 0) pc = a;
        default: ;
      endcase
    end
  endtask

  typedef struct {
    logic [15:0] ins, data, ac0;
    logic [3:0]  alu;
    int          cost;
    logic [15:0] ac;
    logic [11:0] nxt;
    bit          wr;
  } vec_t;

  vec_t vt[15];

  initial begin
    int n, acnt, wcnt, bad, cyc;
    logic [11:0] lf, waddr, a;
    logic [3:0]  alast, op;
    logic [15:0] mac;

    vt[0]  = '{16'h6005, 16'h0000, 16'h0000, 4'h6, L+2,   16'h0005, 12'h001, 1'b0};
    vt[1]  = '{16'h1010, 16'h0007, 16'h0005, 4'h1, 2*L+2, 16'h000C, 12'h001, 1'b0};
    vt[2]  = '{16'h2010, 16'h0003, 16'h0005, 4'h2, 2*L+2, 16'h0002, 12'h001, 1'b0};
    vt[3]  = '{16'h3010, 16'h0007, 16'h0006, 4'h3, 2*L+2, 16'h002A, 12'h001, 1'b0};
    vt[4]  = '{16'h4010, 16'h0004, 16'h0011, 4'h4, 2*L+2, 16'h0004, 12'h001, 1'b0};
    vt[5]  = '{16'h5010, 16'h1234, 16'h0005, 4'h5, 2*L+2, 16'h1234, 12'h001, 1'b0};
    vt[6]  = '{16'h7000, 16'h0000, 16'hFFFF, 4'h7, L+2,   16'h0000, 12'h001, 1'b0};
    vt[7]  = '{16'h8000, 16'h0000, 16'h0000, 4'h8, L+2,   16'hFFFF, 12'h001, 1'b0};
    vt[8]  = '{16'h9000, 16'h0000, 16'h0055, 4'h9, L+2,   16'h0000, 12'h001, 1'b0};
    vt[9]  = '{16'h0000, 16'h0000, 16'h0003, 4'h0, L+2,   16'h0003, 12'h001, 1'b0};
    vt[10] = '{16'hD000, 16'h0000, 16'h0003, 4'h0, L+2,   16'h0003, 12'h001, 1'b0};
    vt[11] = '{16'hB020, 16'h0000, 16'h0003, 4'h0, L+2,   16'h0003, 12'h020, 1'b0};
    vt[12] = '{16'hC020, 16'h0000, 16'h0000, 4'h0, L+2,   16'h0000, 12'h020, 1'b0};
    vt[13] = '{16'hC020, 16'h0000, 16'h0001, 4'h0, L+2,   16'h0001, 12'h001, 1'b0};
    vt[14] = '{16'hA030, 16'h0000, 16'hBEEF, 4'h0, L+2,   16'hBEEF, 12'h001, 1'b1};

    // Reset state while held in reset
    clear_mem();
    mem[0] = 16'h6005; mem[1] = 16'hF000;
    #1;
    chk("reset_outputs", {mem_addr, mem_read, mem_write, ac_to_bus, alu_control, halted, instruction}, 64'h0);

    // First fetch timing and IR / alu_control presentation
    do_reset();
    for (int c = 1; c <= L; c++) begin
      chk($sformatf("fetch_c%0d", c), {mem_read, mem_addr}, {1'b1, 12'h000});
      tick();
    end
    chk("decode_cycle", {mem_read, alu_control, instruction}, {1'b0, 4'h0, 16'h6005});
    tick();
    chk("exec_cycle", {alu_control, instruction}, {4'h6, 16'h6005});
    tick();
    chk("ldc_ac", ac, 16'h0005);

    // Single-instruction vectors, each followed by HLT on both paths
    foreach (vt[i]) begin
      clear_mem();
      mem[0] = vt[i].ins; mem[1] = 16'hF000; mem[12'h020] = 16'hF000; mem[12'h010] = vt[i].data;
      do_reset();
      ac = vt[i].ac0;
      run_to_halt(n, lf, acnt, alast, wcnt, waddr);
      chk($sformatf("v%0d_cycles", i), n, vt[i].cost + SW + L + 2);
      chk($sformatf("v%0d_ac", i), ac, vt[i].ac);
      chk($sformatf("v%0d_next_pc", i), lf, vt[i].nxt);
      chk($sformatf("v%0d_alu_pulses", i), acnt, (vt[i].alu != 0) ? 1 : 0);
      if (vt[i].alu != 0) chk($sformatf("v%0d_alu_code", i), alast, vt[i].alu);
      chk($sformatf("v%0d_writes", i), wcnt, vt[i].wr ? 1 : 0);
      if (vt[i].wr) chk($sformatf("v%0d_store", i), {waddr, mem[12'h030]}, {12'h030, vt[i].ac0});
    end

    // HALT holds with strobes idle
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_read || mem_write || ac_to_bus || alu_control != 0 || !halted) bad++;
      tick();
    end
    chk("halt_hold", bad, 0);

    // PC wrap FFF -> 000
    clear_mem();
    mem[0] = 16'hBFFF; mem[12'hFFF] = 16'h0000;
    do_reset();
    repeat (L + 2 + SW) tick();
    chk("jmp_fff_fetch", {mem_read, mem_addr}, {1'b1, 12'hFFF});
    repeat (L + 2 + SW) tick();
    chk("pc_wrap_fetch", {mem_read, mem_addr}, {1'b1, 12'h000});

    // Reset during OPREAD aborts at once and restarts at 000
    clear_mem();
    mem[0] = 16'h1010; mem[12'h010] = 16'h0009;
    do_reset();
    repeat (L + 1) tick();
    chk("opread_active", {mem_read, mem_addr}, {1'b1, 12'h010});
    reset_n = 1'b0;
    #1;
    chk("reset_abort", {mem_addr, mem_read, mem_write, ac_to_bus, alu_control, halted, instruction}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    repeat (SW) tick();
    chk("restart_fetch", {mem_read, mem_addr}, {1'b1, 12'h000});
    chk("abort_no_alu", ac, 16'h0000);

`ifdef CU_SINGLE_STEP_EN
    // Step gating: idle without step, one instruction per pulse
    clear_mem();
    mem[0] = 16'h6007; mem[1] = 16'h6009;
    @(negedge clock);
    reset_n = 1'b0; step = 1'b0; ac = '0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_read) bad++;
      tick();
    end
    chk("step_idle", bad, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    bad = 0; acnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_read) bad++;
      if (alu_control != 0) acnt++;
      tick();
    end
    chk("step_reads", bad, L);
    chk("step_alu", acnt, 1);
    chk("step_ac", ac, 16'h0007);
`endif

    // Random straight-line programs with forward branches
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      for (int i = 0; i < 8; i++) begin
        op = 4'($urandom_range(0, 14));
        if ((op >= 4'h1 && op <= 4'h5) || op == 4'hA) a = 12'h100 + 12'($urandom_range(0, 15));
        else if (op == 4'hB || op == 4'hC)             a = 12'($urandom_range(i + 1, 8));
        else                                           a = 12'($urandom_range(0, 4095));
        mem[i] = {op, a};
      end
      mem[8] = 16'hF000;
      for (int i = 0; i < 16; i++) mem[12'h100 + i] = ((i % 5) == 0) ? 16'h0 : 16'($urandom);
      for (int i = 0; i < 4096; i++) rm[i] = mem[i];
      model_run(cyc, mac);
      do_reset();
      run_to_halt(n, lf, acnt, alast, wcnt, waddr);
      chk($sformatf("rnd%0d_cycles", t), n, cyc + 1);
      chk($sformatf("rnd%0d_ac", t), ac, mac);
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[12'h100 + i] !== rm[12'h100 + i]) bad++;
      chk($sformatf("rnd%0d_mem", t), bad, 0);
    end

    chk("rd_wr_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
